logic_unit_pipe: RTL



---
 rtl/logic_unit_pkg.sv | 45 ++++
 rtl/logic_unit_stage.sv | 43 ++++
 rtl/logic_unit_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared definitions for the pipelined bitwise logic unit.
//   OPW       - opcode width (fixed at 3)
//   LU_MAX_W  - widest operand logic_op can process; units must use WIDTH < LU_MAX_W
//   op_e      - the eight bitwise operations
//   logic_op  - pure combinational evaluation of one operation
package logic_unit_pkg;

  localparam int OPW      = 3;
  localparam int LU_MAX_W = 1024;

  typedef enum logic [OPW-1:0] {
    OP_NOT   = 3'b000,
    OP_AND   = 3'b001,
    OP_OR    = 3'b010,
    OP_XOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_XNOR  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  // Operands are zero-extended to LU_MAX_W by the caller, which keeps only
  // its own WIDTH low bits of the result (bitwise ops never mix bit lanes).
  function automatic logic [LU_MAX_W-1:0] logic_op(
    input op_e                 op,
    input logic [LU_MAX_W-1:0] a,
    input logic [LU_MAX_W-1:0] b
  );
    logic [LU_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_NOT:   r = ~a;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_PASSB: r = b;
      default:  r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one valid/ready pipeline register holding a W-bit payload.
//   clk, reset           - clock, async active-high reset
//   in_valid/in_ready    - upstream handshake, in_data payload
//   out_valid/out_ready  - downstream handshake, out_data payload
// The stage refills in the same cycle it empties, so it sustains one
// transfer per clock. Payload is cleared on reset and only changes on accept,
// which keeps out_data stable while the downstream stalls.
module logic_unit_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid;
  logic [W-1:0] data;

  assign in_ready  = !valid | out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  // Occupancy flag and payload register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (in_valid & in_ready) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready bitwise logic unit with accumulator.
//   clk, reset           - clock, async active-high reset
//   in_valid/in_ready    - operand handshake; i0 (A), i1 (B), op, use_acc
//   out_valid/out_ready  - result handshake; o = result
//   acc_o                - accumulator register
//   zero_o, par_o        - result==0 and XOR-reduce of result, present only
//                          when LOGIC_UNIT_FLAGS_EN is defined
// S1 captures the raw transaction; the operation is evaluated on the S1->S2
// transfer, which is also the only instant the accumulator is read or written,
// so chained use_acc transactions see each other's results in order.
// WIDTH must be below logic_unit_pkg::LU_MAX_W.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [OPW-1:0]   op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] acc_o
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             par_o
`endif
);

  localparam int S1W = 2 * WIDTH + OPW + 1;
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int S2W = WIDTH + 2;
`else
  localparam int S2W = WIDTH;
`endif

  logic                s1_valid;
  logic [S1W-1:0]      s1_data;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [OPW-1:0]      s1_op;
  logic                s1_use_acc;
  logic                s2_in_ready;
  logic [S2W-1:0]      s2_in_data;
  logic [S2W-1:0]      s2_data;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    a_sel;
  logic [LU_MAX_W-1:0] res_full;
  logic [WIDTH-1:0]    result;
  logic                transfer;
  logic                unused_res_hi;

  logic_unit_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({use_acc, op, i1, i0}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign a_reg      = s1_data[WIDTH-1:0];
  assign b_reg      = s1_data[2*WIDTH-1:WIDTH];
  assign s1_op      = s1_data[2*WIDTH+OPW-1:2*WIDTH];
  assign s1_use_acc = s1_data[S1W-1];

  assign a_sel    = s1_use_acc ? acc : a_reg;
  assign res_full = logic_op(op_e'(s1_op), LU_MAX_W'(a_sel), LU_MAX_W'(b_reg));
  assign result   = res_full[WIDTH-1:0];
  // Lanes above WIDTH are scratch from the zero-extended evaluation.
  assign unused_res_hi = ^res_full[LU_MAX_W-1:WIDTH];

  assign transfer = s1_valid & s2_in_ready;

`ifdef LOGIC_UNIT_FLAGS_EN
  assign s2_in_data = {^result, (result == '0), result};
`else
  assign s2_in_data = result;
`endif

  logic_unit_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign o = s2_data[WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero_o = s2_data[WIDTH];
  assign par_o  = s2_data[WIDTH+1];
`endif

  // Accumulator: written with the result of a use_acc transaction as it moves to S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (transfer & s1_use_acc) begin
      acc <= result;
    end else begin
      acc <= acc;
    end
  end

  assign acc_o = acc;

endmodule
